// File: rtl/gm_fill_arbiter.sv
// gm_fill_arbiter: shares one graphics-memory port between CPU accesses and
// a hardware "fill whole memory with one character" engine.
// Optional feature macro: GM_CPU_PRIORITY_EN. When it is defined, the CPU
// preempts fill writes. When it is undefined, the fill owns the port until
// it completes.
module gm_fill_arbiter #(
  parameter int CELLS = 4800
) (
  input  logic        bus_clk_i,
  input  logic        rst_i,
  input  logic        cpu_en_i,
  input  logic        cpu_wren_i,
  input  logic [12:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_ack_o,
  input  logic        fill_start_i,
  input  logic [7:0]  fill_char_i,
  output logic        fill_busy_o,
  output logic        fill_done_o,
  output logic [12:0] gm_addr_o,
  output logic [7:0]  gm_wdata_o,
  output logic        gm_wren_o,
  input  logic [7:0]  gm_rdata_i
);

  localparam logic [12:0] NCELLS = 13'(CELLS);
  localparam logic [12:0] LAST   = 13'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state;
  logic [12:0] cnt;
  logic [7:0]  fchar;
  logic        grant;
  logic        fill_wr;
  logic        cpu_in_range;

`ifdef GM_CPU_PRIORITY_EN
  // CPU always wins; the fill simply loses that cycle
  assign grant = cpu_en_i;
`else
  // fill owns the port for its whole duration
  assign grant = cpu_en_i && (state != FILL);
`endif

  assign fill_wr      = (state == FILL) && !grant;
  assign cpu_in_range = (cpu_addr_i < NCELLS);
  assign cpu_rdata_o  = gm_rdata_i;

  // memory port mux: CPU grant, else fill write, else idle zeros
  always_comb begin
    gm_addr_o  = '0;
    gm_wdata_o = '0;
    gm_wren_o  = 1'b0;
    if (grant) begin
      // out-of-range CPU accesses are swallowed but still acknowledged
      if (cpu_in_range) begin
        gm_addr_o  = cpu_addr_i;
        gm_wren_o  = cpu_wren_i;
        gm_wdata_o = cpu_wren_i ? cpu_wdata_i : 8'h00;
      end
    end else if (fill_wr) begin
      gm_addr_o  = cnt;
      gm_wdata_o = fchar;
      gm_wren_o  = 1'b1;
    end
  end

  // fill FSM with registered ack/busy/done
  always_ff @(posedge bus_clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      fchar       <= '0;
      cpu_ack_o   <= 1'b0;
      fill_busy_o <= 1'b0;
      fill_done_o <= 1'b0;
    end else begin
      cpu_ack_o <= grant;
      case (state)
        IDLE: begin
          if (fill_start_i) begin
            fchar       <= fill_char_i;
            cnt         <= '0;
            state       <= FILL;
            fill_busy_o <= 1'b1;
          end
        end
        FILL: begin
          // counter only moves on cycles that actually wrote
          if (fill_wr) begin
            if (cnt == LAST) begin
              state       <= DONE;
              fill_done_o <= 1'b1;
            end else begin
              cnt <= cnt + 13'd1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          fill_done_o <= 1'b0;
          fill_busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gm_fill_arbiter.sv
// Directed bench for gm_fill_arbiter with a 1-cycle-latency memory model.
module tb_gm_fill_arbiter;

  logic        bus_clk_i = 1'b0;
  logic        rst_i, cpu_en_i, cpu_wren_i, fill_start_i;
  logic [12:0] cpu_addr_i;
  logic [7:0]  cpu_wdata_i, fill_char_i, gm_rdata_i;
  logic [7:0]  cpu_rdata_o, gm_wdata_o;
  logic        cpu_ack_o, fill_busy_o, fill_done_o, gm_wren_o;
  logic [12:0] gm_addr_o;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [7:0] mem [0:8191];

  gm_fill_arbiter dut (
    .bus_clk_i(bus_clk_i), .rst_i(rst_i),
    .cpu_en_i(cpu_en_i), .cpu_wren_i(cpu_wren_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o),
    .fill_start_i(fill_start_i), .fill_char_i(fill_char_i),
    .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o),
    .gm_addr_o(gm_addr_o), .gm_wdata_o(gm_wdata_o), .gm_wren_o(gm_wren_o),
    .gm_rdata_i(gm_rdata_i)
  );

  always #5 bus_clk_i = ~bus_clk_i;

  // synchronous RAM model
  always @(posedge bus_clk_i) begin
    if (gm_wren_o) mem[gm_addr_o] <= gm_wdata_o;
    gm_rdata_i <= mem[gm_addr_o];
  end

  always @(posedge bus_clk_i) if (fill_done_o) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs are then driven 1ns after the edge
  task automatic tick();
    @(posedge bus_clk_i);
    #1;
  endtask

  initial begin
    int bad, acks, n;
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    rst_i = 1; cpu_en_i = 0; cpu_wren_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
    fill_start_i = 0; fill_char_i = 0;
    tick(); tick();
    rst_i = 0; #1;
    // reset state and idle port
    check("rst_ack", cpu_ack_o, 0);
    check("rst_busy", fill_busy_o, 0);
    check("rst_done", fill_done_o, 0);
    check("idle_port", {gm_wren_o, gm_addr_o, gm_wdata_o}, 0);

    // CPU write then read of addr 5 in IDLE
    tick();
    cpu_en_i = 1; cpu_wren_i = 1; cpu_addr_i = 13'h0005; cpu_wdata_i = 8'hA5; #1;
    check("wr_port", {gm_wren_o, gm_addr_o, gm_wdata_o}, {1'b1, 13'h0005, 8'hA5});
    tick();
    check("wr_ack", cpu_ack_o, 1);
    cpu_wren_i = 0; #1;
    check("rd_port", {gm_wren_o, gm_addr_o, gm_wdata_o}, {1'b0, 13'h0005, 8'h00});
    tick();
    cpu_en_i = 0; #1;
    check("rd_ack", cpu_ack_o, 1);
    check("rd_data", cpu_rdata_o, 8'hA5);
    tick();
    check("ack_drop", cpu_ack_o, 0);

    // out-of-range CPU write
    cpu_en_i = 1; cpu_wren_i = 1; cpu_addr_i = 13'h12C0; cpu_wdata_i = 8'h55; #1;
    check("oor_port", {gm_wren_o, gm_addr_o}, 0);
    tick();
    cpu_en_i = 0; cpu_wren_i = 0; #1;
    check("oor_ack", cpu_ack_o, 1);

    // full fill with 8'h20, restart pulse mid-fill ignored
    fill_start_i = 1; fill_char_i = 8'h20;
    tick();
    fill_start_i = 0; #1;
    check("fill_busy", fill_busy_o, 1);
    bad = 0;
    for (int i = 0; i < 4800; i++) begin
      if (!(gm_wren_o === 1'b1 && gm_addr_o === 13'(i) && gm_wdata_o === 8'h20 && fill_done_o === 1'b0)) bad++;
      if (i == 50) begin fill_start_i = 1; fill_char_i = 8'h77; end
      if (i == 51) fill_start_i = 0;
      tick();
    end
    check("fill_seq_bad", bad, 0);
    check("fill_done_pulse", {fill_done_o, fill_busy_o, gm_wren_o}, 3'b110);
    tick();
    check("fill_done_clear", {fill_done_o, fill_busy_o}, 2'b00);
    check("done_cnt1", done_cnt, 1);
    check("mem_last", mem[4799], 8'h20);
    cpu_en_i = 1; cpu_wren_i = 0; cpu_addr_i = 13'h0005;
    tick();
    cpu_en_i = 0; #1;
    check("readback5", {cpu_ack_o, cpu_rdata_o}, {1'b1, 8'h20});

    // CPU request while fill is at counter 100
    tick();
    fill_start_i = 1; fill_char_i = 8'h33;
    tick();
    fill_start_i = 0;
    for (int i = 0; i < 100; i++) tick();
    cpu_en_i = 1; cpu_wren_i = 0; cpu_addr_i = 13'h0007; #1;
    bad = 0; acks = 0;
`ifdef GM_CPU_PRIORITY_EN
    for (int k = 0; k < 3; k++) begin
      if (!(gm_addr_o === 13'h0007 && gm_wren_o === 1'b0)) bad++;
      tick();
      acks += int'(cpu_ack_o);
    end
    cpu_en_i = 0; #1;
    check("prio_port_bad", bad, 0);
    check("prio_acks", acks, 3);
    check("prio_resume", {gm_wren_o, gm_addr_o}, {1'b1, 13'd100});
    n = 0;
    while (fill_done_o !== 1'b1 && n < 6000) begin tick(); n++; end
    check("prio_done_seen", fill_done_o, 1);
    tick();
`else
    for (int k = 0; k < 3; k++) begin
      if (!(gm_addr_o === 13'(100 + k) && gm_wren_o === 1'b1)) bad++;
      tick();
      acks += int'(cpu_ack_o);
    end
    check("nopri_port_bad", bad, 0);
    check("nopri_acks", acks, 0);
    n = 0;
    while (fill_done_o !== 1'b1 && n < 6000) begin
      acks += int'(cpu_ack_o);
      tick(); n++;
    end
    check("nopri_done_seen", fill_done_o, 1);
    check("nopri_no_ack_in_fill", acks, 0);
    check("nopri_done_grant", gm_addr_o, 13'h0007);
    tick();
    cpu_en_i = 0; #1;
    check("nopri_ack_after", cpu_ack_o, 1);
`endif
    check("done_cnt2", done_cnt, 2);

    // reset at counter 2000 aborts the fill
    tick();
    fill_start_i = 1; fill_char_i = 8'h44;
    tick();
    fill_start_i = 0;
    for (int i = 0; i < 2000; i++) tick();
    check("abort_at", {gm_wren_o, gm_addr_o}, {1'b1, 13'd2000});
    rst_i = 1;
    tick();
    rst_i = 0; #1;
    check("abort_busy", {fill_busy_o, fill_done_o, gm_wren_o}, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (gm_wren_o !== 1'b0 || fill_done_o !== 1'b0) bad++;
      tick();
    end
    check("abort_quiet", bad, 0);
    check("done_cnt_abort", done_cnt, 2);
    fill_start_i = 1; fill_char_i = 8'h66;
    tick();
    fill_start_i = 0; #1;
    check("restart", {gm_wren_o, gm_addr_o, gm_wdata_o}, {1'b1, 13'd0, 8'h66});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
